// File: rtl/sync_fifo_rd_port.sv
// Read-side port of the synchronous FIFO: pops the controller/RAM pair
// and presents words on a valid/ready stream at one word per clock.
//
// Ports:
//   clk, reset   : shared clock, synchronous active-high reset
//   empty        : controller empty flag (registered upstream)
//   rd           : pop strobe to the controller (combinational)
//   rd_data      : RAM read data, valid the cycle after rd
//   m_valid      : output word valid (decoded from registered state)
//   m_data       : output word, buffer head (registered)
//   m_ready      : downstream accept
//   level        : buffered word count, 0..2
module sync_fifo_rd_port #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             empty,
   output logic             rd,
   input  logic [WIDTH-1:0] rd_data,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic [1:0]       level
);

   localparam logic [1:0] BUF0 = 2'd0;
   localparam logic [1:0] BUF1 = 2'd1;
   localparam logic [1:0] BUF2 = 2'd2;

   logic [1:0]       cnt_q, cnt_d;
   logic             inflight_q, inflight_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;

   logic       pop;
   logic       push;
   logic [2:0] space;

   always_comb begin
      pop  = (cnt_q != BUF0) && m_ready;
      push = inflight_q;

      // Credits: free slots not already claimed by a read in flight,
      // plus the slot being vacated by this cycle's pop.
      space = 3'd2 - {1'b0, cnt_q} - {2'b0, inflight_q}
            + {2'b0, pop};

      rd         = !empty && !reset && (space != 3'd0);
      inflight_d = rd;

      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;

      case (cnt_q)
         BUF0: begin
            if (push) begin
               head_d = rd_data;
               cnt_d  = BUF1;
            end
         end
         BUF1: begin
            if (push && pop) begin
               // Head leaves while the new word arrives: it
               // replaces the head directly.
               head_d = rd_data;
            end else if (push) begin
               tail_d = rd_data;
               cnt_d  = BUF2;
            end else if (pop) begin
               cnt_d = BUF0;
            end
         end
         BUF2: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = BUF1;
            end
         end
         default: begin
            cnt_d = BUF0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= BUF0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   assign m_valid = (cnt_q != BUF0);
   assign m_data  = head_q;
   assign level   = cnt_q;

endmodule
